// File: rtl/seq_pattern_ctrl.sv
// rtl/seq_pattern_ctrl.sv - programmable serial pattern detector with cfg handshake and saturating match counter
//
// Purpose: accepts a pattern configuration in IDLE, arms, then detects the
// pattern on a serial bit stream while in RUN, pulsing out for one cycle per
// match and counting matches since the last start.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_valid    configuration offered
//   cfg_ready    configuration accepted this cycle if cfg_valid (IDLE only)
//   cfg_pattern  pattern; bit [len-1] is the first bit on the wire
//   cfg_len      pattern length (0 -> 1, >MAXLEN -> MAXLEN)
//   cfg_overlap  1 = overlapping matches allowed
//   start        begin detection (ARMED only)
//   stop         end detection (RUN only)
//   in           serial data bit
//   in_valid     qualifies in
//   out          registered one-cycle match pulse
//   busy         high in RUN
//   match_count  matches since last start, saturating
//   count_sat    sticky, set when an increment is attempted at all-ones
module seq_pattern_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [MAXLEN-1:0]              cfg_pattern,
  input  logic [$clog2(MAXLEN+1)-1:0]    cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           in,
  input  logic                           in_valid,
  output logic                           out,
  output logic                           busy,
  output logic [CNTW-1:0]                match_count,
  output logic                           count_sat
);

  localparam int LW = $clog2(MAXLEN+1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic              ovl_q;
  logic [MAXLEN-1:0] hist_q;
  logic [LW-1:0]     fill_q;
  logic              out_q;
  logic [CNTW-1:0]   cnt_q;
  logic              sat_q;

  logic              cfg_fire;
  logic              start_fire;
  logic [LW-1:0]     len_clamped;
  logic [MAXLEN-1:0] hist_nx;
  logic [LW-1:0]     fill_inc;
  logic [MAXLEN-1:0] mask;
  logic              match;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = ARMED;
      end
      ARMED: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_fire   = cfg_valid && (state_q == IDLE);
  assign start_fire = start && (state_q == ARMED);

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)              len_clamped = LW'(1);
    else if (cfg_len > LW'(MAXLEN)) len_clamped = LW'(MAXLEN);
  end

  // Match is judged on the history/fill including the bit being sampled now.
  assign hist_nx  = {hist_q[MAXLEN-2:0], in};
  assign fill_inc = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len_q));
  end

  assign match = (state_q == RUN) && in_valid && (fill_inc >= len_q) &&
                 (((hist_nx ^ pat_q) & mask) == '0);

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= '0;
      len_q  <= LW'(1);
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      out_q <= match;
      if (cfg_fire) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
        ovl_q <= cfg_overlap;
      end
      if (start_fire) begin
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
        sat_q  <= 1'b0;
      end else if ((state_q == RUN) && in_valid) begin
        hist_q <= hist_nx;
        // Without overlap, restart filling so no matched bit is reused.
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
        if (match) begin
          if (&cnt_q) sat_q <= 1'b1;
          else        cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule
